// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
// The FSM states, the default operand width and the divide-by-zero quotient are defined here.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One radix-2 non-restoring division iteration (combinational).
// Shifts {rem,quo} left, adds or subtracts the divisor by the old remainder sign, and appends the new quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] dvs_ext;

  // The shift drops the remainder's top bit. The remainder after the add or subtract
  // always lies in [-d, d), so the result is still correct modulo 2^(WIDTH+1).
  assign rem_sh  = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign dvs_ext = {1'b0, dvs_i};

  assign rem_o = rem_i[WIDTH] ? (rem_sh + dvs_ext) : (rem_sh - dvs_ext);
  assign quo_o = {quo_i[WIDTH-2:0], ~rem_o[WIDTH]};

endmodule : div_step

// File: rtl/div32_seq.sv
// Multi-cycle signed/unsigned divider: WIDTH non-restoring steps followed by a sign-fixup cycle.
// It produces the quotient (LO) and remainder (HI) under a start/busy/done handshake.
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_out_q, dbz_out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] rem_mag;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // A negative final remainder is restored by adding the divisor back.
  assign rem_mag = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvs_q) : rem_q[WIDTH-1:0];

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_out_d   = dbz_out_q;
    done_d      = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        // The completion cycle sits in IDLE with busy still high; start is ignored until it ends.
        if (done_q) begin
          busy_d = 1'b0;
        end else if (start) begin
          busy_d    = 1'b1;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = cond_neg(dividend, is_signed & dividend[WIDTH-1]);
          dvs_d     = cond_neg(divisor, is_signed & divisor[WIDTH-1]);
          neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = is_signed & dividend[WIDTH-1];
          dbz_d     = (divisor == '0);
          state_d   = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = FIX;
      end
      FIX: begin
        done_d    = 1'b1;
        state_d   = IDLE;
        dbz_out_d = dbz_q;
        // On divide-by-zero quo_q still holds |dividend|; re-applying its sign recovers the original dividend.
        if (dbz_q) begin
          quotient_d  = DBZ_QUOTIENT;
          remainder_d = cond_neg(quo_q, neg_rem_q);
        end else begin
          quotient_d  = cond_neg(quo_q, neg_quo_q);
          remainder_d = cond_neg(rem_mag, neg_rem_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: the datapath registers are reset with the control state, because a mid-operation
    // reset must also zero the visible results.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_out_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_out_q   <= dbz_out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_out_q;

endmodule : div32_seq

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq: it checks results, latency, handshake, ignored start and mid-operation reset.
module tb_div32_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_asserts = 0;
  int n_fail    = 0;

  div32_seq dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one division and checks latency (clocks from the accept edge to the done edge, inclusive),
  // the results and the handshake.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dbz);
    int lat;
    @(negedge clock);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 1;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_at_done"}, 32'(busy), 32'd1);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " remainder"}, remainder, exp_r);
    check({tag, " dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    @(posedge clock); #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " busy_fall"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_div("s 100/7",      1'b1, 32'd100,        32'd7,          34, 32'd14,         32'd2,          1'b0);
    run_div("s -100/7",     1'b1, 32'hFFFF_FF9C,  32'd7,          34, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
    run_div("u ffffffff/16",1'b0, 32'hFFFF_FFFF,  32'h10,         34, 32'h0FFF_FFFF,  32'hF,          1'b0);
    run_div("s 7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  34, 32'hFFFF_FFFD,  32'd1,          1'b0);
    run_div("u 5/0",        1'b0, 32'd5,          32'd0,           2, 32'hFFFF_FFFF,  32'd5,          1'b1);
    run_div("u 6/3",        1'b0, 32'd6,          32'd3,          34, 32'd2,          32'd0,          1'b0);
    run_div("s -7/0",       1'b1, 32'hFFFF_FFF9,  32'd0,           2, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1);
    run_div("s min/-1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  34, 32'h8000_0000,  32'd0,          1'b0);
    run_div("u 80000000/3", 1'b0, 32'h8000_0000,  32'd3,          34, 32'h2AAA_AAAA,  32'd2,          1'b0);

    // A start pulse while busy must be ignored; the original 100/7 result is expected.
    @(negedge clock);
    start = 1'b1; is_signed = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    @(negedge clock);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check("busy start latency", 32'(lat), 32'd34);
    check("busy start quotient", quotient, 32'd14);
    check("busy start remainder", remainder, 32'd2);
    @(posedge clock); #1;
    check("busy start done_pulse", 32'(done), 32'd0);

    // A start in the cycle right after done is accepted.
    run_div("u 9/3 after done", 1'b0, 32'd9, 32'd3, 34, 32'd3, 32'd0, 1'b0);

    // A reset in the middle of an operation aborts it: outputs clear and no done appears.
    @(negedge clock);
    start = 1'b1; is_signed = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    while (lat < 15) begin
      @(posedge clock); #1;
      lat++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset quotient", quotient, 32'd0);
    check("midreset remainder", remainder, 32'd0);
    check("midreset done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    check("midreset no_done", 32'(seen), 32'd0);
    check("midreset idle busy", 32'(busy), 32'd0);

    run_div("s 100/7 after reset", 1'b1, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_div32_seq
